// File: rtl/cache_valid_controller.sv
// Write-port sequencer for a cache valid-bit array.
// Fills and invalidates are merged with a full-cache flush sweep into one
// registered write stream for the valid array. Invalidate outranks fill,
// and while a sweep runs no new updates are accepted.
module cache_valid_controller #(
  parameter int NUM_SETS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_en,
  input  logic [ADDR_WIDTH-1:0] fill_set,
  output logic                  fill_ack,
  input  logic                  inv_en,
  input  logic [ADDR_WIDTH-1:0] inv_set,
  output logic                  inv_ack,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  va_wr_enable,
  output logic [ADDR_WIDTH-1:0] va_wr_addr,
  output logic                  va_wr_is_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic                  in_idle;

  localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(NUM_SETS - 1);

  // Acks depend only on the request lines and the registered state; invalidate wins a tie.
  always_comb begin
    in_idle    = (state == IDLE);
    inv_ack    = in_idle && inv_en;
    fill_ack   = in_idle && fill_en && !inv_en;
    flush_busy = (state == SWEEP) || (state == DONE);
    flush_done = (state == DONE);
  end

  // Sequencer: one valid-array write per cycle from an update or the sweep counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sweep_cnt      <= '0;
      va_wr_enable   <= 1'b0;
      va_wr_addr     <= '0;
      va_wr_is_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_ack) begin
            va_wr_enable   <= 1'b1;
            va_wr_addr     <= inv_set;
            va_wr_is_valid <= 1'b0;
          end else if (fill_ack) begin
            va_wr_enable   <= 1'b1;
            va_wr_addr     <= fill_set;
            va_wr_is_valid <= 1'b1;
          end else begin
            va_wr_enable   <= 1'b0;
          end
          if (flush_req) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end
        end
        SWEEP: begin
          va_wr_enable   <= 1'b1;
          va_wr_addr     <= sweep_cnt;
          va_wr_is_valid <= 1'b0;
          sweep_cnt      <= sweep_cnt + ADDR_WIDTH'(1);
          if (sweep_cnt == LAST_SET) begin
            state <= DONE;
          end
        end
        DONE: begin
          va_wr_enable <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          va_wr_enable <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
